// File: rtl/spike_decoder.sv
`default_nettype none
// ============================================================================
// Module      : spike_decoder
// Description : Counts neuron_7 / neuron_8 spikes over a WINDOW-cycle window
//               and reports both totals plus the winning class. Define
//               SPIKE_COUNT_SAT_EN to saturate the counters instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_decoder #(
    parameter int WINDOW = 32,
    parameter int CNT_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             neuron_7,
    input  logic             neuron_8,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [1:0]       winner,
    output logic [CNT_W-1:0] count7,
    output logic [CNT_W-1:0] count8
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(WINDOW - 1);

    state_t           state_q, state_d;
    logic [7:0]       win_q, win_d;
    logic [CNT_W-1:0] cnt7_q, cnt7_d, cnt8_q, cnt8_d;
    logic [CNT_W-1:0] count7_q, count7_d, count8_q, count8_d;
    logic [1:0]       winner_q, winner_d;
    logic             busy_q, busy_d, valid_q, valid_d;
    logic [CNT_W-1:0] inc7, inc8;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic hit);
`ifdef SPIKE_COUNT_SAT_EN
        return (hit && (c != {CNT_W{1'b1}})) ? c + 1'b1 : c;
`else
        return hit ? c + 1'b1 : c;
`endif
    endfunction

    always_comb begin
        inc7     = bump(cnt7_q, neuron_7);
        inc8     = bump(cnt8_q, neuron_8);
        state_d  = state_q;
        win_d    = win_q;
        cnt7_d   = cnt7_q;
        cnt8_d   = cnt8_q;
        count7_d = count7_q;
        count8_d = count8_q;
        winner_d = winner_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_COUNT;
                    busy_d   = 1'b1;
                    win_d    = 8'd0;
                    cnt7_d   = '0;
                    cnt8_d   = '0;
                    count7_d = '0;
                    count8_d = '0;
                    winner_d = 2'b00;
                end
            end
            S_COUNT: begin
                cnt7_d = inc7;
                cnt8_d = inc8;
                // The final sample is folded straight into the reported result.
                if (win_q == LAST_IDX) begin
                    state_d  = S_HOLD;
                    valid_d  = 1'b1;
                    count7_d = inc7;
                    count8_d = inc8;
                    winner_d = (inc7 > inc8) ? 2'b01 :
                               (inc8 > inc7) ? 2'b10 : 2'b00;
                end else begin
                    win_d = win_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (result_ready) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            win_q    <= 8'd0;
            cnt7_q   <= '0;
            cnt8_q   <= '0;
            count7_q <= '0;
            count8_q <= '0;
            winner_q <= 2'b00;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            cnt7_q   <= cnt7_d;
            cnt8_q   <= cnt8_d;
            count7_q <= count7_d;
            count8_q <= count8_d;
            winner_q <= winner_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign winner       = winner_q;
    assign count7       = count7_q;
    assign count8       = count8_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_decoder
// Description : Scoreboard bench for spike_decoder; two instances (CNT_W 6 and 4)
//               share stimulus so counter overflow behaviour is also observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_decoder;

    localparam int WIN = 32;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic       n7 = 1'b0, n8 = 1'b0, ready = 1'b0;
    logic       busy_a, valid_a, busy_b, valid_b;
    logic [1:0] win_a, win_b;
    logic [5:0] c7_a, c8_a;
    logic [3:0] c7_b, c8_b;
    int         checks = 0, errors = 0, cyc = 0;

    typedef struct {
        int e7a, e8a, ewa, e7b, e8b, ewb, ecyc;
    } exp_t;
    exp_t q[$];

    spike_decoder #(.WINDOW(WIN), .CNT_W(6)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .neuron_7(n7), .neuron_8(n8),
        .busy(busy_a), .result_valid(valid_a), .result_ready(ready),
        .winner(win_a), .count7(c7_a), .count8(c8_a));

    spike_decoder #(.WINDOW(WIN), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .neuron_7(n7), .neuron_8(n8),
        .busy(busy_b), .result_valid(valid_b), .result_ready(ready),
        .winner(win_b), .count7(c7_b), .count8(c8_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: true spike total reduced to a w-bit counter's reading.
    function automatic int fold(input int n, input int w);
`ifdef SPIKE_COUNT_SAT_EN
        return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
`else
        return n % (1 << w);
`endif
    endfunction

    function automatic int pick(input int a, input int b);
        return (a > b) ? 1 : ((b > a) ? 2 : 0);
    endfunction

    function automatic exp_t make_exp(input int t7, input int t8, input int ecyc);
        exp_t e;
        e.e7a  = fold(t7, 6);
        e.e8a  = fold(t8, 6);
        e.ewa  = pick(e.e7a, e.e8a);
        e.e7b  = fold(t7, 4);
        e.e8b  = fold(t8, 4);
        e.ewb  = pick(e.e7b, e.e8b);
        e.ecyc = ecyc;
        return e;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy_a"}, busy_a, 0);
        chk({tag, "_valid_a"}, valid_a, 0);
        chk({tag, "_winner_a"}, win_a, 0);
        chk({tag, "_count7_a"}, c7_a, 0);
        chk({tag, "_count8_a"}, c8_a, 0);
        chk({tag, "_busy_b"}, busy_b, 0);
        chk({tag, "_valid_b"}, valid_b, 0);
        chk({tag, "_count7_b"}, c7_b, 0);
    endtask

    // mode: 0 random, 1 neuron_7 only, 2 both on alternate cycles, 3 silent.
    // hold_len < 0 picks a random HOLD duration.
    task automatic run_window(input int mode, input int hold_len);
        int t7 = 0, t8 = 0, p7, p8, hl, ecyc;
        p7 = $urandom_range(0, 100);
        p8 = $urandom_range(0, 100);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ecyc = cyc + WIN;
        for (int i = 0; i < WIN; i++) begin
            if (i == 5) begin
                chk("busy_in_count", busy_a, 1);
                chk("valid_in_count", valid_a, 0);
            end
            case (mode)
                1: begin n7 = 1'b1; n8 = 1'b0; end
                2: begin n7 = (i % 2 == 0); n8 = (i % 2 == 0); end
                3: begin n7 = 1'b0; n8 = 1'b0; end
                default: begin
                    n7 = ($urandom_range(0, 99) < p7);
                    n8 = ($urandom_range(0, 99) < p8);
                end
            endcase
            start = ($urandom_range(0, 9) == 0);
            ready = 1'($urandom_range(0, 1));
            t7 += int'(n7);
            t8 += int'(n8);
            if (i == WIN - 1) q.push_back(make_exp(t7, t8, ecyc));
            @(posedge clk); #1;
        end
        hl = (hold_len < 0) ? $urandom_range(0, 12) : hold_len;
        repeat (hl) begin
            ready = 1'b0;
            start = 1'($urandom_range(0, 1));
            n7 = 1'($urandom_range(0, 1));
            n8 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        start = 1'b0;
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        repeat ($urandom_range(0, 3)) begin
            n7 = 1'($urandom_range(0, 1));
            n8 = 1'($urandom_range(0, 1));
            ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        ready = 1'b0;
    endtask

    task automatic apply_reset(input string tag);
        #1 rst_n = 1'b0;
        #1 chk_all_zero(tag);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n7 = 1'b0;
        n8 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_window();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n7 = 1'b1;
        n8 = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        apply_reset("rst_mid");
    endtask

    task automatic reset_in_hold();
        int ecyc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ecyc = cyc + WIN;
        n7 = 1'b1;
        n8 = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            if (i == WIN - 1) q.push_back(make_exp(WIN, 0, ecyc));
            @(posedge clk); #1;
        end
        ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        apply_reset("rst_hold");
    endtask

    initial begin : monitor
        logic pv, pr;
        exp_t cur;
        pv = 1'b0;
        pr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                continue;
            end
            if (valid_a && !pv) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result valid=1 with no pending window (t=%0t)", $time);
                end else begin
                    cur = q.pop_front();
                    chk("latency", cyc, cur.ecyc);
                    chk("count7_a", c7_a, cur.e7a);
                    chk("count8_a", c8_a, cur.e8a);
                    chk("winner_a", win_a, cur.ewa);
                    chk("busy_in_hold", busy_a, 1);
                    chk("valid_b", valid_b, 1);
                    chk("count7_b", c7_b, cur.e7b);
                    chk("count8_b", c8_b, cur.e8b);
                    chk("winner_b", win_b, cur.ewb);
                end
            end else if (valid_a && pv) begin
                chk("hold_count7_a", c7_a, cur.e7a);
                chk("hold_count8_a", c8_a, cur.e8a);
                chk("hold_winner_a", win_a, cur.ewa);
                chk("hold_count7_b", c7_b, cur.e7b);
            end else if (!valid_a && pv) begin
                chk("accept_ready_seen", pr, 1);
                chk("accept_busy_a", busy_a, 0);
                chk("accept_valid_b", valid_b, 0);
                chk("retain_count7_a", c7_a, cur.e7a);
                chk("retain_winner_a", win_a, cur.ewa);
            end
            pv = valid_a;
            pr = ready;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_window(1, 10);
        run_window(2, -1);
        run_window(3, -1);
        reset_mid_window();
        run_window(1, -1);
        reset_in_hold();
        for (int k = 0; k < 20; k++) run_window(0, -1);
        repeat (5) @(posedge clk);
        #1 chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
